// File: rtl/twosum_sched_pkg.sv
// Shared types and helpers for the twosum merge scheduler.
package twosum_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sched_state_e;

    // Counter width able to hold 0..max_pairs inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_pairs);
        return $clog2(max_pairs + 1);
    endfunction

endpackage

// File: rtl/twosum_issue_tracker.sv
// Delay line marking which cycles carry a returned merge result.
module twosum_issue_tracker #(
    parameter int unsigned LAT = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic issue,
    output logic ret_v
);

    logic [LAT-1:0] pipe_q;

    // Shift the issue strobe along; the oldest stage lines up with the unit output.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= (pipe_q << 1) | LAT'(issue);
        end
    end

    assign ret_v = pipe_q[LAT-1];

endmodule

// File: rtl/twosum_merge_sched.sv
// Folds N compensated (sum, error) pairs into one through a shared pipelined merge unit.
//
// state | meaning
// IDLE  | waiting for start_i
// RUN   | accepting pairs, issuing merges, recirculating returned results
// DONE  | final pair on res_*, res_valid_o high for this single cycle
module twosum_merge_sched
    import twosum_sched_pkg::*;
#(
    parameter int unsigned EXP_WIDTH_I  = 5,
    parameter int unsigned MANT_WIDTH_I = 2,
    parameter int unsigned MERGE_LAT    = 3,
    parameter int unsigned MAX_PAIRS    = 64,
    localparam int unsigned BIT_WIDTH_I = 1 + EXP_WIDTH_I + MANT_WIDTH_I,
    localparam int unsigned CNT_W       = cnt_width(MAX_PAIRS)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic [CNT_W-1:0]       n_pairs_i,
    output logic                   busy_o,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [BIT_WIDTH_I-1:0] in_sum_i,
    input  logic [BIT_WIDTH_I-1:0] in_error_i,
    output logic                   mrg_valid_o,
    output logic [BIT_WIDTH_I-1:0] mrg_sum_a_o,
    output logic [BIT_WIDTH_I-1:0] mrg_error_a_o,
    output logic [BIT_WIDTH_I-1:0] mrg_sum_b_o,
    output logic [BIT_WIDTH_I-1:0] mrg_error_b_o,
    input  logic [BIT_WIDTH_I-1:0] mrg_sum_i,
    input  logic [BIT_WIDTH_I-1:0] mrg_error_i,
    output logic                   res_valid_o,
    output logic [BIT_WIDTH_I-1:0] res_sum_o,
    output logic [BIT_WIDTH_I-1:0] res_error_o
);

    typedef struct packed {
        logic [BIT_WIDTH_I-1:0] sum;
        logic [BIT_WIDTH_I-1:0] error;
    } pair_t;

    sched_state_e state_q, state_d;

    logic [CNT_W-1:0] n_q, acc_q, ret_cnt_q;
    logic             hold_valid_q;
    pair_t            hold_q;

    logic  ret_v, ret_live, accept, last_ret;
    pair_t ret_pair, in_pair;

    logic  issue, hold_load, hold_clr, res_load;
    pair_t op_a, op_b, hold_d, res_d;

    twosum_issue_tracker #(.LAT(MERGE_LAT)) u_tracker (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .clr   (state_q == IDLE),
        .issue (mrg_valid_o),
        .ret_v (ret_v)
    );

    assign ret_pair   = '{sum: mrg_sum_i, error: mrg_error_i};
    assign in_pair    = '{sum: in_sum_i, error: in_error_i};
    assign ret_live   = ret_v && (state_q == RUN);
    // Refusing input while H and R coincide keeps every cycle at two sources or fewer.
    assign in_ready_o = (state_q == RUN) && (acc_q < n_q) && !(hold_valid_q && ret_live);
    assign accept     = in_valid_i && in_ready_o;
    assign last_ret   = ret_live && ((ret_cnt_q + CNT_W'(1)) == (n_q - CNT_W'(1)));
    assign busy_o     = (state_q != IDLE);
    assign res_valid_o = (state_q == DONE);

    // Next state and operand pairing for this cycle's sources (R, H, I).
    always_comb begin
        state_d   = state_q;
        issue     = 1'b0;
        op_a      = hold_q;
        op_b      = ret_pair;
        hold_load = 1'b0;
        hold_clr  = 1'b0;
        hold_d    = in_pair;
        res_load  = 1'b0;
        res_d     = '0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (n_pairs_i == '0) begin
                        state_d  = DONE;
                        res_load = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (n_q == CNT_W'(1) && accept) begin
                    res_load = 1'b1;
                    res_d    = in_pair;
                    state_d  = DONE;
                end else if (last_ret) begin
                    res_load = 1'b1;
                    res_d    = ret_pair;
                    state_d  = DONE;
                end else if (hold_valid_q && ret_live) begin
                    issue    = 1'b1;
                    op_a     = hold_q;
                    op_b     = ret_pair;
                    hold_clr = 1'b1;
                end else if (hold_valid_q && accept) begin
                    issue    = 1'b1;
                    op_a     = hold_q;
                    op_b     = in_pair;
                    hold_clr = 1'b1;
                end else if (ret_live && accept) begin
                    issue = 1'b1;
                    op_a  = ret_pair;
                    op_b  = in_pair;
                end else if (ret_live) begin
                    hold_load = 1'b1;
                    hold_d    = ret_pair;
                end else if (accept) begin
                    hold_load = 1'b1;
                    hold_d    = in_pair;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register, registered merge issue and result latch.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            mrg_valid_o   <= 1'b0;
            mrg_sum_a_o   <= '0;
            mrg_error_a_o <= '0;
            mrg_sum_b_o   <= '0;
            mrg_error_b_o <= '0;
            res_sum_o     <= '0;
            res_error_o   <= '0;
        end else begin
            state_q     <= state_d;
            mrg_valid_o <= issue;
            if (issue) begin
                mrg_sum_a_o   <= op_a.sum;
                mrg_error_a_o <= op_a.error;
                mrg_sum_b_o   <= op_b.sum;
                mrg_error_b_o <= op_b.error;
            end
            if (res_load) begin
                res_sum_o   <= res_d.sum;
                res_error_o <= res_d.error;
            end
        end
    end

    // Single-entry hold slot for an operand waiting for a partner.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            hold_valid_q <= 1'b0;
            hold_q       <= '0;
        end else if (state_q != RUN) begin
            hold_valid_q <= 1'b0;
        end else if (hold_clr) begin
            hold_valid_q <= 1'b0;
        end else if (hold_load) begin
            hold_valid_q <= 1'b1;
            hold_q       <= hold_d;
        end
    end

    // Job size, accepted-input and returned-result counters.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            n_q       <= '0;
            acc_q     <= '0;
            ret_cnt_q <= '0;
        end else if (state_q == IDLE) begin
            if (start_i) begin
                n_q <= n_pairs_i;
            end
            acc_q     <= '0;
            ret_cnt_q <= '0;
        end else if (state_q == RUN) begin
            if (accept) begin
                acc_q <= acc_q + CNT_W'(1);
            end
            if (ret_live) begin
                ret_cnt_q <= ret_cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_twosum_merge_sched.sv
// Bench for twosum_merge_sched: E5M2 merge-unit model, per-job reference model, scoreboard monitor.
module tb_twosum_merge_sched;

    localparam int LAT  = 3;
    localparam int MAXP = 64;
    localparam int CW   = $clog2(MAXP + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic [CW-1:0] n_pairs_i = '0;
    logic          busy_o, in_ready_o, mrg_valid_o, res_valid_o;
    logic          in_valid_i = 1'b0;
    logic [7:0]    in_sum_i = '0, in_error_i = '0;
    logic [7:0]    mrg_sum_a_o, mrg_error_a_o, mrg_sum_b_o, mrg_error_b_o;
    logic [7:0]    mrg_sum_i = '0, mrg_error_i = '0;
    logic [7:0]    res_sum_o, res_error_o;

    twosum_merge_sched #(
        .EXP_WIDTH_I(5), .MANT_WIDTH_I(2), .MERGE_LAT(LAT), .MAX_PAIRS(MAXP)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_i), .n_pairs_i(n_pairs_i), .busy_o(busy_o),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_sum_i(in_sum_i), .in_error_i(in_error_i),
        .mrg_valid_o(mrg_valid_o), .mrg_sum_a_o(mrg_sum_a_o), .mrg_error_a_o(mrg_error_a_o),
        .mrg_sum_b_o(mrg_sum_b_o), .mrg_error_b_o(mrg_error_b_o),
        .mrg_sum_i(mrg_sum_i), .mrg_error_i(mrg_error_i),
        .res_valid_o(res_valid_o), .res_sum_o(res_sum_o), .res_error_o(res_error_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct packed { int due; logic [15:0] r; } ret_t;

    logic [31:0] exp_iss[$];
    logic [15:0] exp_res[$];
    logic [7:0]  vin_s[$], vin_e[$];
    int          iss_seen, res_cyc, last_acc, start_cyc;
    logic [15:0] last_res, exp_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // E5M2 decode (bias 15, subnormals when exponent field is 0).
    function automatic real dec(input logic [7:0] c);
        int  e, m;
        real v;
        e = int'(c[6:2]);
        m = int'(c[1:0]);
        if (e == 0) begin
            v = m / 4.0;
            e = 1;
        end else begin
            v = 1.0 + m / 4.0;
        end
        for (int k = 0; k < 15 - e; k++) v = v / 2.0;
        for (int k = 0; k < e - 15; k++) v = v * 2.0;
        return c[7] ? -v : v;
    endfunction

    // Round to nearest E5M2 code, ties to even mantissa, by exhaustive search.
    function automatic logic [7:0] enc(input real x);
        logic [7:0] best, c;
        real        bd, d;
        best = 8'h00;
        bd   = 1.0e30;
        for (int k = 0; k < 256; k++) begin
            c = k[7:0];
            if (c[6:2] != 5'h1f) begin
                d = dec(c) - x;
                if (d < 0.0) d = -d;
                if (d < bd || (d == bd && c[0] == 1'b0 && best[0] == 1'b1)) begin
                    bd   = d;
                    best = c;
                end
            end
        end
        return best;
    endfunction

    // Twosum merge: rounded total of both pairs, plus the rounded residual.
    function automatic logic [15:0] merge(input logic [15:0] a, input logic [15:0] b);
        real        t;
        logic [7:0] s;
        t = dec(a[15:8]) + dec(a[7:0]) + dec(b[15:8]) + dec(b[7:0]);
        s = enc(t);
        return {s, enc(t - dec(s))};
    endfunction

    function automatic logic [7:0] rnd_sum();
        logic [7:0] v;
        v[7]   = 1'($urandom_range(1));
        v[6:2] = 5'($urandom_range(18, 10));
        v[1:0] = 2'($urandom_range(3));
        return v;
    endfunction

    function automatic logic [7:0] rnd_err();
        logic [7:0] v;
        v = 8'h00;
        if ($urandom_range(1) == 1) begin
            v[7]   = 1'($urandom_range(1));
            v[6:2] = 5'($urandom_range(8));
            v[1:0] = 2'($urandom_range(3));
        end
        return v;
    endfunction

    // External merge unit with latency LAT; garbage on its outputs when nothing returns.
    ret_t unit_q[$];
    always @(negedge clk) begin
        ret_t t;
        if (mrg_valid_o === 1'b1) begin
            t.due = cyc + LAT;
            t.r   = merge({mrg_sum_a_o, mrg_error_a_o}, {mrg_sum_b_o, mrg_error_b_o});
            unit_q.push_back(t);
        end
        while (unit_q.size() > 0 && unit_q[0].due < cyc) void'(unit_q.pop_front());
        if (unit_q.size() > 0 && unit_q[0].due == cyc) begin
            t = unit_q.pop_front();
            mrg_sum_i   = t.r[15:8];
            mrg_error_i = t.r[7:0];
        end else begin
            mrg_sum_i   = 8'($urandom);
            mrg_error_i = 8'($urandom);
        end
    end

    // Scoreboard monitor: pops expectations whenever the DUT issues or reports.
    always @(negedge clk) begin
        logic [31:0] e_iss;
        logic [15:0] e_res;
        if (mrg_valid_o === 1'b1) begin
            iss_seen++;
            check("mrg_only_while_busy", busy_o, 1);
            if (exp_iss.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL mrg_unexpected: got issue %h/%h + %h/%h, required none (cycle %0d)",
                         mrg_sum_a_o, mrg_error_a_o, mrg_sum_b_o, mrg_error_b_o, cyc);
            end else begin
                e_iss = exp_iss.pop_front();
                check("mrg_operands", {mrg_sum_a_o, mrg_error_a_o, mrg_sum_b_o, mrg_error_b_o}, e_iss);
            end
        end
        if (res_valid_o === 1'b1) begin
            res_cyc  = cyc;
            last_res = {res_sum_o, res_error_o};
            if (exp_res.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL res_unexpected: got %h/%h, required no result (cycle %0d)",
                         res_sum_o, res_error_o, cyc);
            end else begin
                e_res = exp_res.pop_front();
                check("result", {res_sum_o, res_error_o}, e_res);
            end
        end
    end

    // Drive one job and predict its issues/result from the pairing rules.
    // abort_at >= 0 pulls reset at that RUN cycle; poke pulses start_i mid-job.
    task automatic run_job(input int n, input int vprob, input int abort_at, input bit poke);
        int          acc, rcnt, c, guard;
        bit          hv, pres, done, aborted, retv, rdy, take, iss;
        logic [7:0]  is_, ie;
        logic [15:0] hp, rp, a, b;
        ret_t        mq[$];
        ret_t        t;
        acc = 0; rcnt = 0; c = 0; hv = 0; pres = 0; done = 0; aborted = 0;
        hp = '0; rp = '0; a = '0; b = '0;
        guard = 0;
        while (busy_o !== 1'b0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("idle_before_start", busy_o, 0);
        iss_seen  = 0;
        start_cyc = cyc;
        start_i   = 1'b1;
        n_pairs_i = CW'(n);
        if (n == 0) begin
            exp_res.push_back(16'h0000);
            exp_last = 16'h0000;
            done     = 1;
        end
        @(negedge clk);
        start_i   = 1'b0;
        n_pairs_i = '0;
        while (!done && !aborted && c < 4000) begin
            retv = 0;
            if (mq.size() > 0 && mq[0].due == cyc) begin
                t    = mq.pop_front();
                rp   = t.r;
                retv = 1;
            end
            rdy = (acc < n) && !(hv && retv);
            check("busy_in_run", busy_o, 1);
            check("in_ready", in_ready_o, rdy);
            if (c == abort_at) begin
                in_valid_i = 1'b0;
                rst_n      = 1'b0;
                aborted    = 1;
            end else begin
                if (acc < n && !pres && $urandom_range(99) < vprob) pres = 1;
                is_ = pres ? vin_s[acc] : 8'($urandom);
                ie  = pres ? vin_e[acc] : 8'($urandom);
                in_valid_i = pres;
                in_sum_i   = is_;
                in_error_i = ie;
                start_i    = poke && (c == 2);
                n_pairs_i  = (poke && c == 2) ? CW'(7) : '0;
                take = pres && rdy;
                if (take) begin
                    acc++;
                    pres     = 0;
                    last_acc = cyc;
                end
                iss = 0;
                if (n == 1 && take) begin
                    exp_res.push_back({is_, ie});
                    exp_last = {is_, ie};
                    done = 1;
                end else if (retv && rcnt + 1 == n - 1) begin
                    exp_res.push_back(rp);
                    exp_last = rp;
                    done = 1;
                end else begin
                    if (retv) rcnt++;
                    if (hv && retv) begin
                        iss = 1; a = hp; b = rp; hv = 0;
                    end else if (hv && take) begin
                        iss = 1; a = hp; b = {is_, ie}; hv = 0;
                    end else if (retv && take) begin
                        iss = 1; a = rp; b = {is_, ie};
                    end else if (retv) begin
                        hp = rp; hv = 1;
                    end else if (take) begin
                        hp = {is_, ie}; hv = 1;
                    end
                end
                if (iss) begin
                    exp_iss.push_back({a, b});
                    t.due = cyc + 1 + LAT;
                    t.r   = merge(a, b);
                    mq.push_back(t);
                end
                @(negedge clk);
                c++;
            end
        end
        in_valid_i = 1'b0;
        start_i    = 1'b0;
        n_pairs_i  = '0;
        if (aborted) begin
            @(negedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            check("abort_no_pending_issue", exp_iss.size(), 0);
            check("abort_busy", busy_o, 0);
            check("abort_mrg_valid", mrg_valid_o, 0);
            check("abort_res_valid", res_valid_o, 0);
            exp_iss.delete();
            return;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL job_timeout: n=%0d still running after %0d cycles, required completion", n, c);
            return;
        end
        @(negedge clk);
        @(negedge clk);
        check("busy_after_done", busy_o, 0);
        check("no_leftover_issue", exp_iss.size(), 0);
        check("no_leftover_result", exp_res.size(), 0);
        check("res_hold", {res_sum_o, res_error_o}, exp_last);
    endtask

    task automatic load_inputs(input int n);
        vin_s.delete();
        vin_e.delete();
        for (int i = 0; i < n; i++) begin
            vin_s.push_back(rnd_sum());
            vin_e.push_back(rnd_err());
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", busy_o, 0);
        check("rst_in_ready", in_ready_o, 0);
        check("rst_mrg_valid", mrg_valid_o, 0);
        check("rst_res_valid", res_valid_o, 0);
        check("rst_res", {res_sum_o, res_error_o}, 0);
        check("rst_mrg_ops", {mrg_sum_a_o, mrg_error_a_o, mrg_sum_b_o, mrg_error_b_o}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // N=1: direct copy, one cycle after acceptance.
        vin_s = '{8'h3C};
        vin_e = '{8'h00};
        run_job(1, 100, -1, 0);
        check("n1_result", last_res, 16'h3C00);
        check("n1_latency", res_cyc, last_acc + 1);
        check("n1_issues", iss_seen, 0);

        // N=2: one merge, result MERGE_LAT+2 after the second accept.
        vin_s = '{8'h3C, 8'h3C};
        vin_e = '{8'h00, 8'h00};
        run_job(2, 100, -1, 0);
        check("n2_result", last_res, 16'h4000);
        check("n2_latency", res_cyc, last_acc + LAT + 2);
        check("n2_issues", iss_seen, 1);

        // N=0: immediate DONE with zero result.
        run_job(0, 100, -1, 0);
        check("n0_result", last_res, 16'h0000);
        check("n0_latency", res_cyc, start_cyc + 1);
        check("n0_issues", iss_seen, 0);

        // N=4 back-to-back.
        vin_s = '{8'h3C, 8'h40, 8'h44, 8'h3C};
        vin_e = '{8'h00, 8'h00, 8'h00, 8'h00};
        run_job(4, 100, -1, 0);
        check("n4_issues", iss_seen, 3);

        // Reset two cycles into an N=4 job, then a clean N=2 job.
        run_job(4, 100, 2, 0);
        check("abort_issues", iss_seen, 1);
        vin_s = '{8'h3C, 8'h3C};
        vin_e = '{8'h00, 8'h00};
        run_job(2, 100, -1, 0);
        check("post_abort_result", last_res, 16'h4000);
        check("post_abort_issues", iss_seen, 1);

        // start_i while busy must not disturb the running job.
        load_inputs(5);
        run_job(5, 70, -1, 1);
        check("poke_issues", iss_seen, 4);

        // Randomized jobs with random producer gaps.
        for (int j = 0; j < 14; j++) begin
            int n;
            n = (j < 3) ? MAXP : int'($urandom_range(MAXP, 1));
            load_inputs(n);
            run_job(n, int'($urandom_range(100, 20)), -1, 0);
            check("rand_issues", iss_seen, n - 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

endmodule
